// File: rtl/trans_mes_buf.sv
// Transmit-side message buffer: latches one CAN message, writes it into the
// Canakari transmit registers, requests transmission and waits for tx_ok.
module trans_mes_buf #(
    parameter logic [15:0] TIMEOUT    = 16'd4096,
    parameter logic [4:0]  ADDR_ID    = 5'b01001,
    parameter logic [4:0]  ADDR_D12   = 5'b01000,
    parameter logic [4:0]  ADDR_D34   = 5'b00111,
    parameter logic [4:0]  ADDR_D56   = 5'b00110,
    parameter logic [4:0]  ADDR_D78   = 5'b00100,
    parameter logic [4:0]  ADDR_CTRL  = 5'b01111,
    parameter logic [15:0] CTRL_TXREQ = 16'h0001
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [75:0] data_tra_in,
    input  logic [3:0]  dlc,
    input  logic        wr_ack,
    input  logic        tx_ok,
    output logic [4:0]  addr,
    output logic [15:0] data_tra_out,
    output logic        we,
    output logic        busy,
    output logic        done,
    output logic        tx_err
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] WR_ID   = 3'd1;
    localparam logic [2:0] WR_D12  = 3'd2;
    localparam logic [2:0] WR_D34  = 3'd3;
    localparam logic [2:0] WR_D56  = 3'd4;
    localparam logic [2:0] WR_D78  = 3'd5;
    localparam logic [2:0] WR_CTRL = 3'd6;
    localparam logic [2:0] WAIT_TX = 3'd7;

    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    logic [2:0]  state_q, state_d;
    logic [63:0] msg_q, msg_d;
    logic [15:0] cnt_q, cnt_d;
    logic [4:0]  addr_d;
    logic [15:0] data_d;
    logic        we_d, busy_d, done_d, tx_err_d;
    logic        acked;

    // Only id[10:0] reaches the ID register word.
    logic unused_id_msb;
    assign unused_id_msb = data_tra_in[75];

    assign acked = we && wr_ack;

    // Next state and next registered outputs.
    always_comb begin
        state_d  = state_q;
        msg_d    = msg_q;
        cnt_d    = cnt_q;
        addr_d   = addr;
        data_d   = data_tra_out;
        we_d     = we;
        busy_d   = busy;
        done_d   = 1'b0;
        tx_err_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = WR_ID;
                    msg_d   = data_tra_in[63:0];
                    addr_d  = ADDR_ID;
                    data_d  = {data_tra_in[74:64], 1'b0, dlc};
                    we_d    = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            WR_ID: begin
                if (acked) begin
                    state_d = WR_D12;
                    addr_d  = ADDR_D12;
                    data_d  = msg_q[63:48];
                end
            end
            WR_D12: begin
                if (acked) begin
                    state_d = WR_D34;
                    addr_d  = ADDR_D34;
                    data_d  = msg_q[47:32];
                end
            end
            WR_D34: begin
                if (acked) begin
                    state_d = WR_D56;
                    addr_d  = ADDR_D56;
                    data_d  = msg_q[31:16];
                end
            end
            WR_D56: begin
                if (acked) begin
                    state_d = WR_D78;
                    addr_d  = ADDR_D78;
                    data_d  = msg_q[15:0];
                end
            end
            WR_D78: begin
                if (acked) begin
                    state_d = WR_CTRL;
                    addr_d  = ADDR_CTRL;
                    data_d  = CTRL_TXREQ;
                end
            end
            WR_CTRL: begin
                if (acked) begin
                    state_d = WAIT_TX;
                    addr_d  = 5'd0;
                    data_d  = 16'd0;
                    we_d    = 1'b0;
                    cnt_d   = 16'd0;
                end
            end
            WAIT_TX: begin
                // tx_ok wins over a timeout landing in the same cycle.
                if (tx_ok) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else if (cnt_q == TIMEOUT - 16'd1) begin
                    state_d  = IDLE;
                    busy_d   = 1'b0;
                    tx_err_d = 1'b1;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = IDLE;
                addr_d  = 5'd0;
                data_d  = 16'd0;
                we_d    = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State, latch, counter and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            msg_q        <= 64'd0;
            cnt_q        <= 16'd0;
            addr         <= 5'd0;
            data_tra_out <= 16'd0;
            we           <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            tx_err       <= 1'b0;
        end else begin
            state_q      <= state_d;
            msg_q        <= msg_d;
            cnt_q        <= cnt_d;
            addr         <= addr_d;
            data_tra_out <= data_d;
            we           <= we_d;
            busy         <= busy_d;
            done         <= done_d;
            tx_err       <= tx_err_d;
        end
    end

endmodule

// File: tb/tb_trans_mes_buf.sv
// Bench for trans_mes_buf: transaction-level model checked every cycle, plus
// literal expectations for write sequences, stalls, timeout and reset.
module tb_trans_mes_buf;

    localparam logic [15:0] TO = 16'd16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [75:0] data_tra_in = '0;
    logic [3:0]  dlc = '0;
    logic        wr_ack = 1'b0;
    logic        tx_ok = 1'b0;
    logic [4:0]  addr;
    logic [15:0] data_tra_out;
    logic        we, busy, done, tx_err;

    int checks = 0;
    int errors = 0;
    int ncyc = 0;
    int done_cnt = 0;
    int err_cnt = 0;

    logic [4:0]  log_a[$];
    logic [15:0] log_d[$];
    int          log_c[$];

    always #5 clk = ~clk;

    trans_mes_buf #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .start(start), .data_tra_in(data_tra_in),
        .dlc(dlc), .wr_ack(wr_ack), .tx_ok(tx_ok), .addr(addr),
        .data_tra_out(data_tra_out), .we(we), .busy(busy), .done(done),
        .tx_err(tx_err)
    );

    // Model: index into the list of six register writes, -1 idle, 6 waiting.
    logic [15:0] m_words[6];
    logic [4:0]  m_addrs[6];
    int          m_idx = -1;
    int          m_wait = 0;
    logic        m_done = 1'b0;
    logic        m_err = 1'b0;

    initial m_addrs = '{5'h09, 5'h08, 5'h07, 5'h06, 5'h04, 5'h0F};

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_idx = -1; m_wait = 0; m_done = 1'b0; m_err = 1'b0;
        end else begin
            m_done = 1'b0; m_err = 1'b0;
            if (m_idx < 0) begin
                if (start) begin
                    m_words[0] = {data_tra_in[74:64], 1'b0, dlc};
                    for (int j = 0; j < 4; j++)
                        m_words[j+1] = data_tra_in[63-16*j -: 16];
                    m_words[5] = 16'h0001;
                    m_idx = 0;
                end
            end else if (m_idx < 6) begin
                if (wr_ack) begin
                    m_idx++;
                    m_wait = 0;
                end
            end else begin
                m_wait++;
                if (tx_ok) begin
                    m_done = 1'b1; m_idx = -1;
                end else if (m_wait == int'(TO)) begin
                    m_err = 1'b1; m_idx = -1;
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model; also logs accepted writes.
    always @(negedge clk) begin
        logic        e_we;
        logic [4:0]  e_addr;
        logic [15:0] e_data;
        ncyc++;
        e_we   = (m_idx >= 0) && (m_idx < 6);
        e_addr = e_we ? m_addrs[m_idx] : 5'd0;
        e_data = e_we ? m_words[m_idx] : 16'd0;
        chk("cyc_we", 32'(we), 32'(e_we));
        chk("cyc_addr", 32'(addr), 32'(e_addr));
        chk("cyc_data", 32'(data_tra_out), 32'(e_data));
        chk("cyc_busy", 32'(busy), 32'(m_idx >= 0));
        chk("cyc_done", 32'(done), 32'(m_done));
        chk("cyc_tx_err", 32'(tx_err), 32'(m_err));
        if (we && wr_ack) begin
            log_a.push_back(addr);
            log_d.push_back(data_tra_out);
            log_c.push_back(ncyc);
        end
        if (done) done_cnt++;
        if (tx_err) err_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        log_a.delete(); log_d.delete(); log_c.delete();
    endtask

    task automatic send_start(input logic [75:0] msg, input logic [3:0] d);
        data_tra_in = msg;
        dlc = d;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_wait_tx(output int c);
        c = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            #1;
            if (busy && !we) begin
                c = ncyc;
                break;
            end
        end
        if (c < 0) begin
            checks++;
            errors++;
            $display("FAIL wait_tx_entry actual=not_reached required=reached");
        end
    endtask

    // Literal write sequence for the 0x601 message with dlc 8.
    task automatic check_log(input string nm, input bit consecutive);
        logic [4:0]  ea[6];
        logic [15:0] ed[6];
        ea = '{5'b01001, 5'b01000, 5'b00111, 5'b00110, 5'b00100, 5'b01111};
        ed = '{16'hC028, 16'h4000, 16'h1000, 16'h0000, 16'h0000, 16'h0001};
        chk({nm, "_count"}, 32'(log_a.size()), 32'd6);
        if (log_a.size() == 6) begin
            for (int i = 0; i < 6; i++) begin
                chk({nm, "_addr"}, 32'(log_a[i]), 32'(ea[i]));
                chk({nm, "_data"}, 32'(log_d[i]), 32'(ed[i]));
                if (consecutive)
                    chk({nm, "_cycle"}, 32'(log_c[i] - log_c[0]), 32'(i));
            end
        end
    endtask

    logic [75:0] msg601, msg581;
    int c0, c1, dc;

    initial begin
        msg601 = {12'h601, 8'h40, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        msg581 = {12'h581, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};

        repeat (2) tick();
        chk("rst_we", 32'(we), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_addr", 32'(addr), 32'd0);
        chk("rst_data", 32'(data_tra_out), 32'd0);
        rst = 1'b0;
        tick();

        // Basic send, wr_ack tied high.
        clear_log();
        wr_ack = 1'b1;
        send_start(msg601, 4'd8);
        chk("basic_wr_id_addr", 32'(addr), 32'h09);
        chk("basic_wr_id_data", 32'(data_tra_out), 32'hC028);
        wait_wait_tx(c0);
        check_log("basic", 1'b1);
        tick(); tick();
        tx_ok = 1'b1;
        tick();
        tx_ok = 1'b0;
        chk("basic_done", 32'(done), 32'd1);
        chk("basic_busy_low", 32'(busy), 32'd0);
        tick();
        chk("basic_done_pulse", 32'(done), 32'd0);

        // Stall on WR_D12 for four cycles.
        clear_log();
        wr_ack = 1'b0;
        send_start(msg601, 4'd8);
        wr_ack = 1'b1;
        tick();
        wr_ack = 1'b0;
        c1 = 0;
        for (int i = 0; i < 4; i++) begin
            if (we && addr == 5'b01000 && data_tra_out == 16'h4000) c1++;
            tick();
        end
        wr_ack = 1'b1;
        if (we && addr == 5'b01000 && data_tra_out == 16'h4000) c1++;
        chk("stall_hold_cycles", 32'(c1), 32'd5);
        wait_wait_tx(c0);
        check_log("stall", 1'b0);
        tx_ok = 1'b1;
        tick();
        tx_ok = 1'b0;
        tick();

        // Async reset in the middle of WR_D34.
        clear_log();
        wr_ack = 1'b1;
        send_start(msg601, 4'd8);
        tick();
        tick();
        wr_ack = 1'b0;
        chk("pre_rst_addr", 32'(addr), 32'b00111);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_we", 32'(we), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_addr", 32'(addr), 32'd0);
        chk("arst_data", 32'(data_tra_out), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_tx_err", 32'(tx_err), 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // start while busy and spurious tx_ok during WR_ID are ignored.
        clear_log();
        dc = done_cnt;
        wr_ack = 1'b0;
        send_start(msg601, 4'd8);
        data_tra_in = msg581;
        start = 1'b1;
        tx_ok = 1'b1;
        tick();
        start = 1'b0;
        tx_ok = 1'b0;
        wr_ack = 1'b1;
        wait_wait_tx(c0);
        check_log("busy_start", 1'b1);
        chk("spurious_tx_ok_done", 32'(done_cnt - dc), 32'd0);
        tx_ok = 1'b1;
        tick();
        tx_ok = 1'b0;
        tick();

        // Timeout without tx_ok.
        dc = done_cnt;
        send_start(msg601, 4'd8);
        wait_wait_tx(c0);
        c1 = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #1;
            if (tx_err) begin
                c1 = ncyc;
                break;
            end
        end
        chk("timeout_latency", 32'(c1 - c0), 32'd16);
        chk("timeout_no_done", 32'(done_cnt - dc), 32'd0);
        tick();
        chk("timeout_pulse", 32'(tx_err), 32'd0);

        // tx_ok on the timeout cycle wins.
        dc = err_cnt;
        send_start(msg601, 4'd8);
        wait_wait_tx(c0);
        repeat (15) tick();
        tx_ok = 1'b1;
        tick();
        tx_ok = 1'b0;
        chk("coincide_done", 32'(done), 32'd1);
        chk("coincide_tx_err", 32'(tx_err), 32'd0);
        tick();
        chk("coincide_no_err", 32'(err_cnt - dc), 32'd0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
